// File: rtl/lda_seq.sv
// Sequential linear-discriminant classifier. It uses one shared multiplier and
// accumulator to score every class, then reports the arg-max class and its score.
module lda_seq #(
    parameter int DIMS    = 6,
    parameter int CLASSES = 3,
    parameter int W       = 16,
    localparam int ACC_W  = 2*W + $clog2(DIMS) + 1,
    localparam int CW     = $clog2(CLASSES)
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [DIMS*W-1:0]             din_i,
    input  logic [DIMS*CLASSES*W-1:0]     w_i,
    input  logic [CLASSES*W-1:0]          c_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [CLASSES-1:0]            dout_o,
    output logic [CW-1:0]                 class_o,
    output logic signed [ACC_W-1:0]       score_o
);

    localparam int IW = (DIMS > 1) ? $clog2(DIMS) : 1;

    if (DIMS < 1 || CLASSES < 2) begin : g_bad_params
        $error("lda_seq: DIMS must be >= 1 and CLASSES must be >= 2");
    end

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                   state_q, state_d;
    logic [DIMS*W-1:0]        din_q;
    logic [DIMS*CLASSES*W-1:0] w_q;
    logic [CLASSES*W-1:0]     c_q;
    logic signed [ACC_W-1:0]  acc_q, best_q, score_q;
    logic [CW-1:0]            best_idx_q, class_q, j_q;
    logic [IW-1:0]            i_q;
    logic [CLASSES-1:0]       dout_q;

    logic signed [W-1:0]      x_op, w_op, c_op;
    logic signed [2*W-1:0]    prod;
    logic signed [ACC_W-1:0]  sum, score, win_score;
    logic [CW-1:0]            win_idx;
    logic                     last_i, last_j, better;

    // Shared MAC: one product per cycle; the class score is finished when i wraps.
    always_comb begin
        x_op      = din_q[int'(i_q)*W +: W];
        w_op      = w_q[(int'(i_q)*CLASSES + int'(j_q))*W +: W];
        c_op      = c_q[int'(j_q)*W +: W];
        prod      = x_op * w_op;
        sum       = acc_q + ACC_W'(prod);
        score     = sum - ACC_W'(c_op);
        last_i    = (i_q == IW'(DIMS-1));
        last_j    = (j_q == CW'(CLASSES-1));
        better    = (j_q == '0) || (score > best_q);
        win_score = better ? score : best_q;
        win_idx   = better ? j_q : best_idx_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_o = rstn_i;
                if (in_valid_i) state_d = MAC;
            end
            MAC: begin
                if (last_i && last_j) state_d = DONE;
            end
            DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            acc_q      <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            i_q        <= '0;
            j_q        <= '0;
            dout_q     <= '0;
            class_q    <= '0;
            score_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        din_q <= din_i;
                        w_q   <= w_i;
                        c_q   <= c_i;
                        acc_q <= '0;
                        i_q   <= '0;
                        j_q   <= '0;
                    end
                end
                MAC: begin
                    if (last_i) begin
                        acc_q      <= '0;
                        i_q        <= '0;
                        best_q     <= win_score;
                        best_idx_q <= win_idx;
                        j_q        <= last_j ? '0 : j_q + CW'(1);
                        // Publish the winner while the last class score is still on the wires.
                        if (last_j) begin
                            dout_q  <= CLASSES'(1) << win_idx;
                            class_q <= win_idx;
                            score_q <= win_score;
                        end
                    end else begin
                        acc_q <= sum;
                        i_q   <= i_q + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout_o  = dout_q;
    assign class_o = class_q;
    assign score_o = score_q;

endmodule
